// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer driving an ALU through READ/WRITE phases
//
// Purpose: accepts one (op, a, b) command per cmd handshake, presents it to
// the ALU for one READ cycle and one WRITE cycle, captures the ALU result into
// a response register and persistent carry/zero flags, then holds the response
// until the consumer takes it. Undefined ops bypass the ALU and return an error.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/ready/op/a/b       command handshake and payload
//   alu_a/b/mode/control         drive to the ALU
//   alu_out/overflow/zero        result from the ALU (meaningful during WRITE)
//   rsp_valid/ready/data/...     response handshake and payload
//   flag_c, flag_z, flags_clr    persistent flags and their clear

package alu_sequencer_pkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_NOT  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_AND  = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SHL  = 4'd6,
        ALU_OP_LSHR = 4'd7,
        ALU_OP_ASHR = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2
    } reg_op_t;
endpackage

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  alu_op_t          cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output alu_op_t          alu_mode,
    output reg_op_t          alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             flag_c,
    output logic             flag_z,
    input  logic             flags_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             op_legal;
    logic             op_carry;

    always_comb begin
        op_legal = 1'b0;
        case (cmd_op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_NOT, ALU_OP_OR, ALU_OP_AND,
            ALU_OP_XOR, ALU_OP_SHL, ALU_OP_LSHR, ALU_OP_ASHR: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Only ADD/SUB produce a meaningful overflow; other ops may leave it undriven.
    assign op_carry = (op_q == ALU_OP_ADD) || (op_q == ALU_OP_SUB);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        cmd_ready   = 1'b0;
        alu_control = REG_OP_NONE;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (op_legal) begin
                        // Only legal ops reach the ALU pins, so alu_mode never
                        // carries an undefined encoding.
                        a_d     = cmd_a;
                        b_d     = cmd_b;
                        op_d    = cmd_op;
                        state_d = ST_LOAD;
                    end else begin
                        rsp_data_d = '0;
                        rsp_ovf_d  = 1'b0;
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_LOAD: begin
                alu_control = REG_OP_READ;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                alu_control = REG_OP_WRITE;
                rsp_data_d  = alu_out;
                rsp_zero_d  = alu_zero;
                rsp_ovf_d   = op_carry ? alu_overflow : 1'b0;
                rsp_err_d   = 1'b0;
                flag_z_d    = alu_zero;
                if (op_carry) begin
                    flag_c_d = alu_overflow;
                end
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A clear arriving together with an EXEC capture takes priority.
        if (flags_clr) begin
            flag_c_d = 1'b0;
            flag_z_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_OP_ADD;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_mode     = op_q;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_err      = rsp_err_q;
    assign flag_c       = flag_c_q;
    assign flag_z       = flag_z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    alu_op_t    cmd_op = ALU_OP_ADD;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic [7:0] alu_a, alu_b;
    alu_op_t    alu_mode;
    reg_op_t    alu_control;
    logic [7:0] alu_out = 8'h00;
    logic       alu_overflow = 1'b0;
    logic       alu_zero = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_overflow, rsp_zero, rsp_err;
    logic       flag_c, flag_z;
    logic       flags_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    alu_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_control(alu_control),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .flag_c(flag_c), .flag_z(flag_z), .flags_clr(flags_clr)
    );

    always #5 clk = ~clk;

    function automatic void ref_alu(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] r, output logic c);
        logic [8:0] s;
        c = 1'b0;
        r = 8'h00;
        case (op)
            ALU_OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            ALU_OP_SUB:  begin r = a - b; c = (a < b); end
            ALU_OP_NOT:  r = ~a;
            ALU_OP_OR:   r = a | b;
            ALU_OP_AND:  r = a & b;
            ALU_OP_XOR:  r = a ^ b;
            ALU_OP_SHL:  r = a << b[2:0];
            ALU_OP_LSHR: r = a >> b[2:0];
            ALU_OP_ASHR: r = 8'($signed(a) >>> b[2:0]);
            default:     r = 8'h00;
        endcase
    endfunction

    function automatic logic is_legal(input alu_op_t op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_NOT, ALU_OP_OR, ALU_OP_AND,
            ALU_OP_XOR, ALU_OP_SHL, ALU_OP_LSHR, ALU_OP_ASHR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Bench-side ALU: samples operands on the READ negedge, presents the result
    // during WRITE, and drives junk otherwise (overflow is junk for non-ADD/SUB).
    alu_op_t    alu_lmode = ALU_OP_ADD;
    logic [7:0] alu_la = 8'h00, alu_lb = 8'h00;
    always @(negedge clk) begin
        logic [7:0] r;
        logic       c;
        if (alu_control == REG_OP_READ) begin
            alu_la    = alu_a;
            alu_lb    = alu_b;
            alu_lmode = alu_mode;
        end
        if (alu_control == REG_OP_WRITE) begin
            ref_alu(alu_lmode, alu_la, alu_lb, r, c);
            alu_out  = r;
            alu_zero = (r == 8'h00);
            if (alu_lmode == ALU_OP_ADD || alu_lmode == ALU_OP_SUB) alu_overflow = c;
            else alu_overflow = 1'($urandom);
        end else begin
            alu_out      = 8'($urandom);
            alu_overflow = 1'($urandom);
            alu_zero     = 1'($urandom);
        end
    end

    // Transaction-level model: one outstanding command, age in cycles since accept.
    logic       m_busy = 1'b0;
    int         m_age = 0;
    int         m_lat = 0;
    logic       m_legal = 1'b0;
    alu_op_t    m_op = ALU_OP_ADD;
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_ovf = 1'b0, m_zero = 1'b0, m_err = 1'b0;
    logic       m_fc = 1'b0, m_fz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [7:0] r;
        logic       c;
        if (rst) begin
            m_busy = 1'b0;
            m_fc   = 1'b0;
            m_fz   = 1'b0;
        end else begin
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy  = 1'b1;
                    m_age   = 1;
                    m_legal = is_legal(cmd_op);
                    m_lat   = m_legal ? 3 : 1;
                    if (m_legal) begin
                        m_op = cmd_op;
                        m_a  = cmd_a;
                        m_b  = cmd_b;
                    end
                    ref_alu(cmd_op, cmd_a, cmd_b, r, c);
                    m_data = m_legal ? r : 8'h00;
                    m_zero = m_legal && (r == 8'h00);
                    m_ovf  = m_legal && (cmd_op == ALU_OP_ADD || cmd_op == ALU_OP_SUB) && c;
                    m_err  = !m_legal;
                end
            end else if (m_age >= m_lat) begin
                if (rsp_ready) m_busy = 1'b0;
            end else begin
                if (m_age == 2) begin
                    m_fz = m_zero;
                    if (m_op == ALU_OP_ADD || m_op == ALU_OP_SUB) m_fc = m_ovf;
                end
                m_age++;
            end
            if (flags_clr) begin
                m_fc = 1'b0;
                m_fz = 1'b0;
            end
        end
    endtask

    task automatic check_cycle();
        logic    exp_valid;
        reg_op_t exp_ctrl;
        exp_valid = m_busy && (m_age >= m_lat);
        exp_ctrl  = REG_OP_NONE;
        if (m_busy && m_legal && m_age == 1) exp_ctrl = REG_OP_READ;
        if (m_busy && m_legal && m_age == 2) exp_ctrl = REG_OP_WRITE;
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        chk("alu_control", 32'(alu_control), 32'(exp_ctrl));
        if (m_busy && m_legal && m_age <= 2) begin
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_mode", 32'(alu_mode), 32'(m_op));
        end
        if (exp_valid) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_overflow", 32'(rsp_overflow), 32'(m_ovf));
            chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        chk("flag_c", 32'(flag_c), 32'(m_fc));
        chk("flag_z", 32'(flag_z), 32'(m_fz));
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
        check_cycle();
    endtask

    // Issues one command and returns once the response is up (not yet retired).
    task automatic run_cmd(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                           input logic clr_exec, output int lat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        rsp_ready = 1'b0;
        tick();
        lat       = 1;
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 10) begin
            flags_clr = clr_exec && (lat == 2);
            tick();
            flags_clr = 1'b0;
            lat++;
        end
        chk("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic retire(input int hold);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = ALU_OP_ADD;
        cmd_a     = 8'h01;
        cmd_b     = 8'h01;
        for (int i = 0; i < hold; i++) tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] held;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_mode", 32'(alu_mode), 32'(ALU_OP_ADD));

        run_cmd(ALU_OP_ADD, 8'hF0, 8'h20, 1'b0, lat);
        chk("add_lat", 32'(lat), 32'd3);
        chk("add_data", 32'(rsp_data), 32'h10);
        chk("add_ovf", 32'(rsp_overflow), 32'd1);
        chk("add_zero", 32'(rsp_zero), 32'd0);
        chk("add_flag_c", 32'(flag_c), 32'd1);
        retire(0);

        run_cmd(ALU_OP_SUB, 8'h05, 8'h05, 1'b0, lat);
        chk("sub0_data", 32'(rsp_data), 32'h00);
        chk("sub0_zero", 32'(rsp_zero), 32'd1);
        chk("sub0_ovf", 32'(rsp_overflow), 32'd0);
        chk("sub0_flag_z", 32'(flag_z), 32'd1);
        retire(0);

        run_cmd(ALU_OP_SUB, 8'h03, 8'h05, 1'b0, lat);
        chk("subn_data", 32'(rsp_data), 32'hFE);
        chk("subn_ovf", 32'(rsp_overflow), 32'd1);
        chk("subn_flag_c", 32'(flag_c), 32'd1);
        retire(0);

        run_cmd(ALU_OP_AND, 8'hFF, 8'h0F, 1'b0, lat);
        chk("and_data", 32'(rsp_data), 32'h0F);
        chk("and_ovf", 32'(rsp_overflow), 32'd0);
        chk("and_flag_c", 32'(flag_c), 32'd1);
        chk("and_flag_z", 32'(flag_z), 32'd0);
        held = rsp_data;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("hold_data", 32'(rsp_data), 32'(held));
        chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        retire(0);

        run_cmd(alu_op_t'(4'hC), 8'h12, 8'h34, 1'b0, lat);
        chk("undef_lat", 32'(lat), 32'd1);
        chk("undef_err", 32'(rsp_err), 32'd1);
        chk("undef_data", 32'(rsp_data), 32'd0);
        chk("undef_flag_c", 32'(flag_c), 32'd1);
        retire(1);

        run_cmd(ALU_OP_SUB, 8'h03, 8'h05, 1'b1, lat);
        chk("clr_flag_c", 32'(flag_c), 32'd0);
        chk("clr_rsp_ovf", 32'(rsp_overflow), 32'd1);
        retire(0);

        run_cmd(ALU_OP_ADD, 8'hF0, 8'h20, 1'b0, lat);
        retire(0);
        cmd_valid = 1'b1;
        cmd_op    = ALU_OP_SUB;
        cmd_a     = 8'h03;
        cmd_b     = 8'h05;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("pre_rst_exec", 32'(alu_control), 32'(REG_OP_WRITE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstx_control", 32'(alu_control), 32'(REG_OP_NONE));
        chk("rstx_valid", 32'(rsp_valid), 32'd0);
        chk("rstx_flag_c", 32'(flag_c), 32'd0);
        chk("rstx_alu_a", 32'(alu_a), 32'd0);
        for (int i = 0; i < 5; i++) tick();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 63) == 0);
            cmd_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) cmd_op = alu_op_t'(4'($urandom_range(0, 15)));
            else cmd_op = alu_op_t'(4'($urandom_range(0, 8)));
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? cmd_a : 8'($urandom);
            rsp_ready = 1'($urandom);
            flags_clr = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
